conv_bcd_signo: RTL

Sequential signed-binary to sign-magnitude BCD converter. It consumes the two's-complement result of the subtractor stage (`WIDTH+1` bits, MSB = sign) and produces a sign flag plus `DIGITS` packed BCD digits for the seven-segment display driver. The conversion is iterative (shift-and-add-3, one bit per cycle) under a start/done handshake, so it costs no wide combinational divider.

---
 rtl/conv_bcd_signo.sv | 123 ++++++++++++
 1 files changed

// File: rtl/conv_bcd_signo.sv
// conv_bcd_signo
// Converts a signed two's-complement value (the subtractor result) into a
// sign flag plus packed BCD digits for the seven-segment driver. The
// conversion is iterative shift-and-add-3, one input bit per clock, so no
// wide divider is needed.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request a conversion (sampled only while idle)
//   in_data  - WIDTH+1 bit signed operand, captured when start is accepted
//   busy     - conversion in progress
//   done     - one-cycle pulse when bcd/neg/ovf carry a new result
//   neg      - result was negative (never set for zero)
//   bcd      - DIGITS packed BCD digits, units in bcd[3:0]
//   ovf      - magnitude did not fit in DIGITS digits (bcd = magnitude mod 10^DIGITS)
module conv_bcd_signo #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH:0]        in_data,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic                     sticky;
    logic                     sign;
    logic                     nonzero;
    logic [WIDTH:0]           mag;
    logic [4*DIGITS-1:0]      acc;
    logic [4*DIGITS-1:0]      acc_adj;
    logic signed [WIDTH:0]    in_signed;
    logic [WIDTH:0]           in_mag;

    // Double-dabble correction: any digit >= 5 gets +3 so the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [4*DIGITS-1:0] add3_digits(input logic [4*DIGITS-1:0] a);
        logic [4*DIGITS-1:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // The most negative input negates to 2^WIDTH, which still fits the
    // WIDTH+1 bit unsigned magnitude exactly.
    always_comb begin
        in_signed = $signed(in_data);
        in_mag    = in_signed[WIDTH] ? $unsigned(-in_signed) : $unsigned(in_signed);
        acc_adj   = add3_digits(acc);
    end

    assign busy = (state != IDLE);

    // Control and the visible result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sticky <= 1'b0;
            done   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            bcd    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SHIFT;
                        cnt    <= CNT_W'(WIDTH + 1);
                        sticky <= 1'b0;
                    end
                end
                SHIFT: begin
                    // A bit leaving the top digit means the value needs
                    // more than DIGITS digits.
                    sticky <= sticky | acc_adj[4*DIGITS-1];
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    bcd   <= acc;
                    neg   <= sign & nonzero;
                    ovf   <= sticky;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working datapath; never visible on the outputs, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            sign    <= in_data[WIDTH];
            nonzero <= |in_data;
            mag     <= in_mag;
            acc     <= '0;
        end else if (state == SHIFT) begin
            {acc, mag} <= {acc_adj[4*DIGITS-2:0], mag, 1'b0};
        end
    end

endmodule
